// File: rtl/fact_core_if.sv
// Register-bus bundle between the peripheral address decoder and fact_core.
// Decoder side drives strobes, select and write data; the core returns read data and busy.
interface fact_core_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  we1;
  logic                  we2;
  logic [1:0]            rdsel;
  logic [DATA_WIDTH-1:0] wd;
  logic [DATA_WIDTH-1:0] rd;
  logic                  busy;

  modport master (output we1, output we2, output rdsel, output wd,
                  input rd, input busy);
  modport slave  (input we1, input we2, input rdsel, input wd,
                  output rd, output busy);
endinterface

// File: rtl/fact_core.sv
// Iterative factorial engine: operand/go/status/result registers with a multi-cycle multiply FSM.
// Optional macro FACT_ERR_EN builds the sticky 2xDATA_WIDTH overflow flag; otherwise results wrap silently.
//
// state | meaning
// IDLE  | post-reset, waiting for a start; n and go writable
// CALC  | multiplying res by cnt and counting cnt down; bus writes ignored
// DONE  | result and status held; behaves as IDLE for writes
module fact_core #(
  parameter int N_WIDTH    = 4,
  parameter int DATA_WIDTH = 32
) (
  input logic        clk,
  input logic        rst_n,
  fact_core_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [N_WIDTH-1:0]    n_q, n_d;
  logic [N_WIDTH-1:0]    cnt_q, cnt_d;
  logic                  go_q, go_d;
  logic                  done_q, done_d;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] res_q, res_d;
  logic [DATA_WIDTH-1:0] prod_lo;
  logic [DATA_WIDTH-1:0] rd_mux;
  logic                  unused_wd;

`ifdef FACT_ERR_EN
  logic                    err_d;
  logic [2*DATA_WIDTH-1:0] prod;
  logic                    ovf;

  assign prod    = {{DATA_WIDTH{1'b0}}, res_q} * {{(2*DATA_WIDTH-N_WIDTH){1'b0}}, cnt_q};
  assign prod_lo = prod[DATA_WIDTH-1:0];
  assign ovf     = |prod[2*DATA_WIDTH-1:DATA_WIDTH];
`else
  assign prod_lo = res_q * {{(DATA_WIDTH-N_WIDTH){1'b0}}, cnt_q};
  assign err_q   = 1'b0;
`endif

  assign unused_wd = ^bus.wd[DATA_WIDTH-1:N_WIDTH];

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    cnt_d   = cnt_q;
    go_d    = go_q;
    done_d  = done_q;
    res_d   = res_q;
`ifdef FACT_ERR_EN
    err_d   = err_q;
`endif
    case (state_q)
      CALC: begin
        if (cnt_q <= N_WIDTH'(1)) begin
          state_d = DONE;
          done_d  = 1'b1;
          go_d    = 1'b0;
        end else begin
          res_d = prod_lo;
          cnt_d = cnt_q - N_WIDTH'(1);
`ifdef FACT_ERR_EN
          if (ovf) err_d = 1'b1;
`endif
        end
      end
      default: begin
        if (bus.we1) n_d = bus.wd[N_WIDTH-1:0];
        if (bus.we2) begin
          if (bus.wd[0]) begin
            // start samples the pre-edge n_q, so a same-edge n write only affects the next run
            state_d = CALC;
            go_d    = 1'b1;
            cnt_d   = n_q;
            res_d   = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
            done_d  = 1'b0;
`ifdef FACT_ERR_EN
            err_d   = 1'b0;
`endif
          end else begin
            go_d = 1'b0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      n_q     <= '0;
      cnt_q   <= '0;
      go_q    <= 1'b0;
      done_q  <= 1'b0;
      res_q   <= '0;
`ifdef FACT_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      go_q    <= go_d;
      done_q  <= done_d;
      res_q   <= res_d;
`ifdef FACT_ERR_EN
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    rd_mux = '0;
    case (bus.rdsel)
      2'b00:   rd_mux[N_WIDTH-1:0] = n_q;
      2'b01:   rd_mux[0]           = go_q;
      2'b10:   rd_mux[1:0]         = {err_q, done_q};
      default: rd_mux              = res_q;
    endcase
  end

  assign bus.rd   = rd_mux;
  assign bus.busy = (state_q == CALC);

endmodule

// File: tb/tb_fact_core.sv
// Directed self-checking bench for fact_core: reset, latency, small/limit factorials, CALC write masking.
// Expected status for n=13 follows the FACT_ERR_EN build setting.
module tb_fact_core;

  localparam int DW = 32;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  fact_core_if #(.DATA_WIDTH(DW)) bus ();

  fact_core #(.N_WIDTH(4), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef FACT_ERR_EN
  localparam logic [31:0] STAT13 = 32'd3;
`else
  localparam logic [31:0] STAT13 = 32'd1;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic rd_chk(input logic [1:0] sel, input logic [31:0] exp, input string tag);
    bus.rdsel = sel;
    #1;
    check(tag, bus.rd, exp);
  endtask

  task automatic wr(input logic w1, input logic w2, input logic [31:0] data);
    bus.we1 = w1;
    bus.we2 = w2;
    bus.wd  = data;
    @(posedge clk);
    #1;
    bus.we1 = 1'b0;
    bus.we2 = 1'b0;
    bus.wd  = '0;
  endtask

  // cycles counted from the start edge until busy drops; bounded so a hung FSM still reports
  task automatic wait_done(input int already, output int cyc);
    cyc = already;
    for (int k = 0; k < 40; k++) begin
      if (!bus.busy) break;
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic run(input int n, input logic [31:0] exp_res, input logic [31:0] exp_stat,
                     input string tag);
    int cyc;
    wr(1'b1, 1'b0, 32'(n));
    wr(1'b0, 1'b1, 32'd1);
    wait_done(0, cyc);
    check({tag, "_lat"}, 32'(cyc), (n < 1) ? 32'd1 : 32'(n));
    rd_chk(2'b11, exp_res, {tag, "_res"});
    rd_chk(2'b10, exp_stat, {tag, "_stat"});
  endtask

  initial begin
    int cyc;
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    bus.we1   = 1'b0;
    bus.we2   = 1'b0;
    bus.wd    = '0;
    bus.rdsel = 2'b00;
    #12;
    rd_chk(2'b00, 32'd0, "rst_n");
    rd_chk(2'b01, 32'd0, "rst_go");
    rd_chk(2'b10, 32'd0, "rst_stat");
    rd_chk(2'b11, 32'd0, "rst_res");
    check("rst_busy", 32'(bus.busy), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 5! with per-cycle busy tracking
    wr(1'b1, 1'b0, 32'd5);
    rd_chk(2'b00, 32'd5, "n5_rd");
    wr(1'b0, 1'b1, 32'd1);
    check("f5_busy_S", 32'(bus.busy), 32'd1);
    rd_chk(2'b01, 32'd1, "f5_go");
    rd_chk(2'b10, 32'd0, "f5_stat_calc");
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
      check("f5_busy_mid", 32'(bus.busy), 32'd1);
    end
    @(posedge clk);
    #1;
    check("f5_busy_end", 32'(bus.busy), 32'd0);
    rd_chk(2'b10, 32'd1, "f5_stat");
    rd_chk(2'b01, 32'd0, "f5_go_end");
    rd_chk(2'b11, 32'd120, "f5_res");

    run(0, 32'd1, 32'd1, "f0");
    run(1, 32'd1, 32'd1, "f1");
    run(12, 32'd479001600, 32'd1, "f12");
    run(13, 32'd1932053504, STAT13, "f13");
    run(12, 32'd479001600, 32'd1, "f12_again");

    // writes during CALC are ignored
    wr(1'b1, 1'b0, 32'd6);
    wr(1'b0, 1'b1, 32'd1);
    @(posedge clk);
    #1;
    wr(1'b1, 1'b1, 32'd3);
    wait_done(2, cyc);
    check("f6_lat", 32'(cyc), 32'd6);
    rd_chk(2'b11, 32'd720, "f6_res");
    rd_chk(2'b00, 32'd6, "f6_n_kept");
    run(3, 32'd6, 32'd1, "f3");

    // same-edge n write and start: run uses old n (3), new n (5) is stored
    wr(1'b1, 1'b1, 32'd5);
    wait_done(0, cyc);
    check("sim_lat", 32'(cyc), 32'd3);
    rd_chk(2'b11, 32'd6, "sim_res");
    rd_chk(2'b00, 32'd5, "sim_n_new");

    // reset mid-CALC
    wr(1'b1, 1'b0, 32'd12);
    wr(1'b0, 1'b1, 32'd1);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("mrst_busy", 32'(bus.busy), 32'd0);
    rd_chk(2'b00, 32'd0, "mrst_n");
    rd_chk(2'b01, 32'd0, "mrst_go");
    rd_chk(2'b10, 32'd0, "mrst_stat");
    rd_chk(2'b11, 32'd0, "mrst_res");
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("post_rst_busy", 32'(bus.busy), 32'd0);
    run(5, 32'd120, 32'd1, "f5_post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
